// File: rtl/outstream.sv
// Stream checker. Accepts up to DEPTH signed words from a producer, compares
// each word bit-exactly against a reference table, and reports progress, the
// first mismatch and any write that arrives after the stream is complete.
//
// Ports:
//   clk       - single clock; all state updates on its rising edge
//   rst       - asynchronous active-low reset
//   clear     - synchronous restart to the post-reset state
//   length    - expected word count (values above DEPTH clamp to DEPTH)
//   expected  - reference words, indexed by arrival order
//   write/in  - producer handshake and offered word
//   wready    - registered accept indication (high only while receiving)
//   count     - words accepted so far
//   done      - count reached the effective length
//   mismatch  - sticky, any received word differed from its reference
//   err_idx   - index of the first mismatching word
//   err_got   - word received at err_idx
//   pass      - done and no mismatch (combinational)
//   overrun   - sticky, write seen while done
module outstream #(
  parameter int unsigned DEPTH = 39,
  parameter int unsigned WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [5:0]              length,
  input  logic signed [WIDTH-1:0] expected [0:DEPTH-1],
  input  logic                    write,
  input  logic [WIDTH-1:0]        in,
  output logic                    wready,
  output logic [5:0]              count,
  output logic                    done,
  output logic                    mismatch,
  output logic [5:0]              err_idx,
  output logic [WIDTH-1:0]        err_got,
  output logic                    pass,
  output logic                    overrun
);

  localparam int unsigned CW = 6;

  typedef enum logic {
    RECV = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   eff_len;
  logic [CW-1:0]   count_inc;
  logic [WIDTH-1:0] exp_word;
  logic            hit;

  // Effective length: requests larger than the table clamp to DEPTH.
  always_comb begin
    eff_len = length;
    if (length > CW'(DEPTH)) eff_len = CW'(DEPTH);
  end

  // Reference word for the next arrival; guarded so the index never leaves the table.
  always_comb begin
    exp_word = '0;
    if (count < CW'(DEPTH)) exp_word = expected[count];
  end

  assign hit       = (in == exp_word);
  assign count_inc = count + CW'(1);
  assign pass      = done & ~mismatch;

  // Receive FSM with registered outputs. wready stays low on the first edge
  // after reset/clear, which is where a zero (or already-satisfied) length
  // is detected and the stream finishes without any transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RECV;
      wready   <= 1'b0;
      count    <= '0;
      done     <= 1'b0;
      mismatch <= 1'b0;
      err_idx  <= '0;
      err_got  <= '0;
      overrun  <= 1'b0;
    end else if (clear) begin
      state    <= RECV;
      wready   <= 1'b0;
      count    <= '0;
      done     <= 1'b0;
      mismatch <= 1'b0;
      err_idx  <= '0;
      err_got  <= '0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        RECV: begin
          if (eff_len <= count) begin
            // Length satisfied (zero at start, or dropped below progress).
            state  <= DONE;
            done   <= 1'b1;
            wready <= 1'b0;
          end else if (!wready) begin
            wready <= 1'b1;
          end else if (write) begin
            count <= count_inc;
            if (!hit) begin
              mismatch <= 1'b1;
              if (!mismatch) begin
                err_idx <= count;
                err_got <= in;
              end
            end
            if (count_inc == eff_len) begin
              state  <= DONE;
              done   <= 1'b1;
              wready <= 1'b0;
            end
          end
        end
        DONE: begin
          if (write) overrun <= 1'b1;
        end
        default: begin
          state <= RECV;
        end
      endcase
    end
  end

endmodule
